// File: rtl/mont_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mont_arbiter
// Purpose  : Round-robin sharing of one Montgomery multiplier between two
//            requesters, with start/done sequencing and a watchdog abort.
// Revision : 1.0
// ============================================================================
module mont_arbiter #(
    parameter int W       = 1024,
    parameter int TIMEOUT = 4096,
    parameter int CW      = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         grant0,
    output logic         grant1,
    output logic         done0,
    output logic         done1,
    output logic         err,
    output logic [W-1:0] res,
    output logic         busy,
    output logic         timeout_flag,
    output logic         mult_start,
    output logic [W-1:0] mult_a,
    output logic [W-1:0] mult_b,
    input  logic [W-1:0] mult_res,
    input  logic         mult_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          err_pend_q, err_pend_d;
    logic          tflag_q, tflag_d;
    logic [1:0]    mask_q, mask_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_q, res_d;
    logic          elig0, elig1, win1;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        err_pend_d = err_pend_q;
        tflag_d    = tflag_q;
        mask_d     = 2'b00;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        // The owner of the job that just finished sits out exactly one IDLE cycle
        elig0      = req0 & ~mask_q[0];
        elig1      = req1 & ~mask_q[1];
        win1       = (elig0 && elig1) ? ~last_q : elig1;

        case (state_q)
            S_IDLE: begin
                if (elig0 || elig1) begin
                    owner_d = win1;
                    a_d     = win1 ? a1 : a0;
                    b_d     = win1 ? b1 : b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                // A result arriving on the final watchdog cycle still counts as success
                if (mult_done) begin
                    res_d   = mult_res;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_d      = '0;
                    err_pend_d = 1'b1;
                    tflag_d    = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                last_d     = owner_q;
                mask_d     = owner_q ? 2'b10 : 2'b01;
                err_pend_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            err_pend_q <= 1'b0;
            tflag_q    <= 1'b0;
            mask_q     <= 2'b00;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            err_pend_q <= err_pend_d;
            tflag_q    <= tflag_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign grant0       = busy & ~owner_q;
    assign grant1       = busy & owner_q;
    assign done0        = (state_q == S_RESP) & ~owner_q;
    assign done1        = (state_q == S_RESP) & owner_q;
    assign err          = (state_q == S_RESP) & err_pend_q;
    assign mult_start   = (state_q == S_START);
    assign mult_a       = a_q;
    assign mult_b       = b_q;
    assign res          = res_q;
    assign timeout_flag = tflag_q;

endmodule
`default_nettype wire

// File: tb/tb_mont_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mont_arbiter
// Purpose  : Directed scoreboard bench for mont_arbiter with a delay-model
//            multiplier.
// Revision : 1.0
// ============================================================================
module tb_mont_arbiter;

    localparam int W       = 16;
    localparam int TIMEOUT = 16;
    localparam int CW      = 5;

    logic         clk;
    logic         reset;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         grant0, grant1, done0, done1, err, busy, timeout_flag;
    logic [W-1:0] res;
    logic         mult_start;
    logic [W-1:0] mult_a, mult_b;
    logic [W-1:0] mult_res;
    logic         mult_done;

    mont_arbiter #(.W(W), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .a0           (a0),
        .b0           (b0),
        .req1         (req1),
        .a1           (a1),
        .b1           (b1),
        .grant0       (grant0),
        .grant1       (grant1),
        .done0        (done0),
        .done1        (done1),
        .err          (err),
        .res          (res),
        .busy         (busy),
        .timeout_flag (timeout_flag),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_res     (mult_res),
        .mult_done    (mult_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         owner;
        logic [W-1:0] res;
        logic         err;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           start_cyc = 0;
    int           done_cyc = 0;
    int           last_gap = 0;
    int           cd = -1;
    int           model_delay = 3;
    int           want0 = 0;
    int           want1 = 0;
    int           n_done0 = 0;
    int           n_done1 = 0;
    int           d0_before = 0;
    int           d1_before = 0;
    bit           model_never = 1'b0;
    bit           stray = 1'b0;
    bit           g1_seen = 1'b0;
    logic [W-1:0] m_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic o, input logic [W-1:0] r, input logic e, input int l);
        exp_t x;
        x.owner = o;
        x.res   = r;
        x.err   = e;
        x.lat   = l;
        sb.push_back(x);
    endtask

    task automatic set_reqs();
        req0 = (want0 > 0);
        req1 = (want1 > 0);
    endtask

    // One clock: multiplier model, then output monitor / scoreboard pop.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        mult_done = 1'b0;
        if (stray) begin
            mult_done = 1'b1;
            stray     = 1'b0;
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mult_done = 1'b1;
                mult_res  = m_res;
                cd        = -1;
            end
        end
        if (mult_start) begin
            start_cyc = cyc;
            last_gap  = cyc - done_cyc;
            if (!model_never) begin
                cd    = model_delay;
                m_res = mult_a * mult_b;
            end
        end
        if (grant1) g1_seen = 1'b1;
        chk("exclusive", {grant0 & grant1, done0 & done1, err & ~(done0 | done1)}, 64'd0);
        if (done0 || done1) begin
            done_cyc = cyc;
            if (done0) n_done0++;
            else       n_done1++;
            if (sb.size() == 0) begin
                chk("unexpected_done", {done1, done0}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("owner", done1, e.owner);
                chk("res", res, e.res);
                chk("err", err, e.err);
                chk("latency", cyc - start_cyc, e.lat);
            end
            if (done0 && want0 > 0) want0--;
            if (done1 && want1 > 0) want1--;
        end
        set_reqs();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || want0 != 0 || want1 != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_pending", sb.size(), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        want0 = 0;
        want1 = 0;
        set_reqs();
        tick();
        reset = 1'b0;
        chk("rst_ctrl", {grant0, grant1, done0, done1, err, busy, timeout_flag, mult_start}, 64'd0);
        chk("rst_res", res, 64'd0);
        chk("rst_ops", {mult_a, mult_b}, 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req0      = 1'b0;
        req1      = 1'b0;
        a0        = '0;
        b0        = '0;
        a1        = '0;
        b1        = '0;
        mult_done = 1'b0;
        mult_res  = '0;
        m_res     = '0;
        do_reset();

        // Single job from requester 0
        a0 = 16'd2; b0 = 16'd3; model_delay = 3; g1_seen = 1'b0;
        push_exp(1'b0, 16'h0006, 1'b0, 4);
        want0 = 1;
        set_reqs();
        tick();
        chk("start_latency", mult_start, 64'd1);
        chk("mult_a", mult_a, 64'd2);
        chk("mult_b", mult_b, 64'd3);
        chk("grant0_in_start", grant0, 64'd1);
        drain(100);
        chk("grant1_never", g1_seen, 64'd0);

        // Stray mult_done while idle
        stray = 1'b1;
        tick(); tick(); tick();
        chk("stray_busy", busy, 64'd0);
        chk("stray_res_held", res, 64'd6);

        // Simultaneous requests straight after reset
        do_reset();
        a0 = 16'd5; b0 = 16'd7; a1 = 16'd9; b1 = 16'd11; model_delay = 2;
        push_exp(1'b0, 16'd35, 1'b0, 3);
        push_exp(1'b1, 16'd99, 1'b0, 3);
        want0 = 1; want1 = 1;
        set_reqs();
        drain(200);
        chk("simul_req1_gap", last_gap, 64'd2);

        // Fairness: both requesting continuously for six jobs
        d0_before = n_done0;
        d1_before = n_done1;
        for (int i = 0; i < 6; i++)
            push_exp(i[0], i[0] ? 16'd99 : 16'd35, 1'b0, 3);
        want0 = 3; want1 = 3;
        set_reqs();
        drain(500);
        chk("fair_done0", n_done0 - d0_before, 64'd3);
        chk("fair_done1", n_done1 - d1_before, 64'd3);

        // Back-to-back requester 0: masked for one IDLE cycle
        push_exp(1'b0, 16'd35, 1'b0, 3);
        push_exp(1'b0, 16'd35, 1'b0, 3);
        want0 = 2;
        set_reqs();
        drain(200);
        chk("mask_gap", last_gap, 64'd3);

        // Minimum-length job
        a1 = 16'd100; b1 = 16'd200; model_delay = 1;
        push_exp(1'b1, 16'd20000, 1'b0, 2);
        want1 = 1;
        set_reqs();
        drain(100);

        // Watchdog timeout
        model_never = 1'b1;
        push_exp(1'b0, 16'h0000, 1'b1, TIMEOUT + 1);
        want0 = 1;
        set_reqs();
        drain(200);
        chk("timeout_flag_set", timeout_flag, 64'd1);
        model_never = 1'b0;

        // mult_done on the final watchdog cycle succeeds
        a1 = 16'h1234; b1 = 16'h0003; model_delay = TIMEOUT;
        push_exp(1'b1, 16'h369C, 1'b0, TIMEOUT + 1);
        want1 = 1;
        set_reqs();
        drain(200);
        chk("timeout_flag_sticky", timeout_flag, 64'd1);

        // Reset in the middle of a job, then a late mult_done
        a0 = 16'd5; b0 = 16'd7; model_delay = 8;
        want0 = 1;
        set_reqs();
        tick(); tick(); tick(); tick();
        chk("midop_busy", busy, 64'd1);
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        chk("midop_idle", busy, 64'd0);

        // Requester 1 served normally afterwards
        a1 = 16'd9; b1 = 16'd11; model_delay = 2;
        push_exp(1'b1, 16'd99, 1'b0, 3);
        want1 = 1;
        set_reqs();
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mont_arbiter.md
Name: mont_arbiter

Overview:
- Shares one montgomery multiplier instance between two requesters, e.g. the exponentiation ladder and a precompute/CRT unit, behind the rsa top.
- Arbitrates round-robin, latches the winner's operands and sequences the multiplier start/done handshake.
- Returns the result and a completion pulse to the owner.
- A watchdog aborts jobs whose mult_done never arrives.

Parameters:
- W, 1024, operand/result width in bits.
- TIMEOUT, 4096, max cycles in BUSY before abort; must be >= 2.
- CW, 13, watchdog counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 level request; held until done0.
- a0  in  W  requester 0 operand A; sampled at grant.
- b0  in  W  requester 0 operand B; sampled at grant.
- req1  in  1  requester 1 level request.
- a1  in  W  requester 1 operand A.
- b1  in  W  requester 1 operand B.
- grant0  out  1  high while requester 0 owns the multiplier (START..RESP).
- grant1  out  1  high while requester 1 owns the multiplier.
- done0  out  1  one-cycle completion pulse to requester 0.
- done1  out  1  one-cycle completion pulse to requester 1.
- err  out  1  one-cycle pulse coincident with done0/done1 when the job timed out.
- res  out  W  result register; valid in the done cycle, held until the next RESP.
- busy  out  1  high in any state except IDLE.
- timeout_flag  out  1  sticky, set on any timeout; cleared only by reset.
- mult_start  out  1  one-cycle start pulse to the multiplier.
- mult_a  out  W  latched operand A to the multiplier.
- mult_b  out  W  latched operand B to the multiplier.
- mult_res  in  W  multiplier result.
- mult_done  in  1  multiplier completion pulse.

Behaviour:
- Reset (reset=1 at an edge): state=IDLE; all outputs 0; operand registers 0; res=0; last=1 (requester 0 wins first); mask cleared.
- Reset mid-operation: abort immediately, same values as above. A later stray mult_done is ignored.
- States: IDLE, START, BUSY, RESP.
- IDLE:
  - Eligible requester k has req_k=1 and is not masked.
  - If both are eligible, the winner is the one != last; otherwise the single eligible one wins.
  - On a winner: at the edge, latch a_k/b_k into mult_a/mult_b, set owner=k, go to START.
  - No winner: stay in IDLE.
- START: mult_start=1 for exactly this cycle; watchdog counter cleared; go to BUSY.
- BUSY:
  - Counter increments each cycle.
  - mult_done=1: latch mult_res into res, go to RESP.
  - Counter reaches TIMEOUT-1 without mult_done: res<=0, set err_pending, set timeout_flag, go to RESP.
  - If mult_done and timeout occur in the same cycle, mult_done wins (no error).
- RESP:
  - done_owner=1 for this cycle; err=err_pending.
  - At the edge: last<=owner, mask the owner for the next IDLE cycle only, clear err_pending, go to IDLE.
- mask exists so a requester that deasserts req one cycle after done is not re-granted. The other requester may win in that masked cycle.
- mult_done in IDLE, START or RESP: ignored.
- grant_k is high in START, BUSY and RESP when owner=k; grant0 and grant1 are never both high.
- req changes during START..RESP have no effect on the current job; operands are not resampled.
- Latency: req accepted in IDLE at cycle t → mult_start at t+1. mult_done at cycle d → done/res at d+1 → IDLE at d+2.
- Minimum job length: 4 cycles (mult_done on the first BUSY cycle).

Test Plan:
- Single job: req0 with a0=2, b0=3; model returns 0x6 three cycles after mult_start. Expect mult_start one cycle after req0, mult_a=2, mult_b=3, done0 with res=0x6, err=0, grant1 never high.
- Simultaneous: req0 and req1 rise in the same cycle right after reset. Expect requester 0 served first. Requester 1 is granted in the IDLE cycle after RESP, because requester 0 is masked there.
- Fairness: both requesters re-request continuously for 6 jobs. Expect grants alternate 0,1,0,1,0,1 and done0/done1 counts are 3 each.
- Timeout: TIMEOUT=16, model never asserts mult_done. Expect done0+err in the cycle after 16 BUSY cycles, res=0, timeout_flag=1 persisting until reset.
- Reset mid-op: assert reset during BUSY, then the model pulses mult_done. Expect all outputs 0, no done pulse, next req1 served normally.
- Stray mult_done in IDLE, and mult_done coincident with the last watchdog cycle: the first is ignored; the second produces a normal done, err=0, res equal to the model value.
